// File: rtl/urv_multiply_serial.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Shares the decode/execute stall handshake with the serial divider; 35 cycles per operation.
module urv_multiply_serial (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  output logic        x_stall_req_o,
  input  logic        d_valid_i,
  input  logic        d_is_multiply_i,
  input  logic [31:0] d_rs1_i,
  input  logic [31:0] d_rs2_i,
  input  logic [2:0]  d_fun_i,
  output logic [31:0] x_rd_o
);

  localparam logic [2:0] FUN_MUL    = 3'b000;
  localparam logic [2:0] FUN_MULH   = 3'b001;
  localparam logic [2:0] FUN_MULHSU = 3'b010;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  // The 0..34 step counter is split into a phase and a 5-bit iteration index.
  state_t      state, state_nxt;
  logic [4:0]  iter, iter_nxt;

  logic [2:0]  fun;
  logic [31:0] a, hi, lo;
  logic        neg;

  logic        start, busy, done;
  logic        a_neg, b_neg;
  logic [32:0] sum;
  logic [63:0] prod, prod_fix;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      iter  <= '0;
    end else begin
      state <= state_nxt;
      iter  <= iter_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    iter_nxt  = iter;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ITER;
          iter_nxt  = '0;
        end
      end
      ITER: begin
        if (x_kill_i)
          state_nxt = IDLE;
        else if (iter == '1)
          state_nxt = FIX;
        else
          iter_nxt = iter + 5'd1;
      end
      FIX:  state_nxt = x_kill_i ? IDLE : DONE;
      DONE: begin
        if (x_kill_i || !x_stall_i)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done          = (state == DONE);
    busy          = (state == ITER) || (state == FIX);
    start         = d_valid_i && d_is_multiply_i && !x_kill_i && !busy && !done;
    x_stall_req_o = d_valid_i && d_is_multiply_i && !done;
    a_neg         = d_rs1_i[31] && ((d_fun_i == FUN_MULH) || (d_fun_i == FUN_MULHSU));
    b_neg         = d_rs2_i[31] && (d_fun_i == FUN_MULH);
    sum           = {1'b0, hi} + (lo[0] ? {1'b0, a} : 33'd0);
    prod          = {hi, lo};
    prod_fix      = neg ? ('0 - prod) : prod;
  end

  // Multiplier bits are consumed from lo[0] while product bits shift in from the top.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fun    <= '0;
      a      <= '0;
      hi     <= '0;
      lo     <= '0;
      neg    <= 1'b0;
      x_rd_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            fun <= d_fun_i;
            a   <= a_neg ? ('0 - d_rs1_i) : d_rs1_i;
            lo  <= b_neg ? ('0 - d_rs2_i) : d_rs2_i;
            hi  <= '0;
            neg <= a_neg ^ b_neg;
          end
        end
        ITER: {hi, lo} <= {sum, lo[31:1]};
        FIX:  x_rd_o <= (fun == FUN_MUL) ? prod_fix[31:0] : prod_fix[63:32];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_urv_multiply_serial.sv
// Scoreboard bench for urv_multiply_serial: driver pushes expected results,
// a negedge monitor pops and compares whenever the unit presents a result.
module tb_urv_multiply_serial;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_stall, x_kill, x_stall_req;
  logic        d_valid, d_is_mul;
  logic [31:0] rs1, rs2, rd;
  logic [2:0]  fun;

  typedef struct {
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cnt   = 0;

  always #5 clk = ~clk;

  urv_multiply_serial dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .x_stall_i       (x_stall),
    .x_kill_i        (x_kill),
    .x_stall_req_o   (x_stall_req),
    .d_valid_i       (d_valid),
    .d_is_multiply_i (d_is_mul),
    .d_rs1_i         (rs1),
    .d_rs2_i         (rs2),
    .d_fun_i         (fun),
    .x_rd_o          (rd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Result is taken in the cycle where the request is no longer stalled and the pipeline advances.
  always @(negedge clk) begin
    if (!rst_n || !(d_valid && d_is_mul)) begin
      cnt = 0;
    end else if (x_stall_req) begin
      cnt++;
    end else if (!x_stall) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %h, expected no result", rd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", rd, e.rd);
        if (e.lat >= 0) check("stall_cycles", cnt, e.lat);
      end
      cnt = 0;
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int stall_cycles,
                       input bit kill_first);
    @(posedge clk); #1;
    sb.push_back('{rd: exp, lat: lat});
    d_valid  = 1'b1;
    d_is_mul = 1'b1;
    fun      = f;
    rs1      = a;
    rs2      = b;
    x_stall  = (stall_cycles > 0);
    x_kill   = kill_first;
    if (kill_first) begin
      @(posedge clk); #1;
      x_kill = 1'b0;
    end
  endtask

  task automatic finish_op(input int stall_cycles, input logic [31:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!x_stall_req) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: stall request still high after 100 cycles, expected DONE");
    end
    for (int i = 0; i < stall_cycles; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_hold_rd", rd, exp);
      check("stall_hold_req", {31'd0, x_stall_req}, 32'd0);
      @(posedge clk); #1;
    end
    if (stall_cycles > 0) begin
      x_stall = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    d_valid  = 1'b0;
    d_is_mul = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input int stall_cycles,
                        input bit kill_first);
    issue(f, a, b, exp, lat, stall_cycles, kill_first);
    finish_op(stall_cycles, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    x_stall  = 1'b0;
    x_kill   = 1'b0;
    d_valid  = 1'b0;
    d_is_mul = 1'b0;
    rs1      = '0;
    rs2      = '0;
    fun      = '0;
    #3;
    check("reset_rd", rd, 32'd0);
    check("reset_req_idle", {31'd0, x_stall_req}, 32'd0);
    d_valid  = 1'b1;
    d_is_mul = 1'b1;
    #1;
    check("reset_req_pending", {31'd0, x_stall_req}, 32'd1);
    d_valid  = 1'b0;
    d_is_mul = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(MUL,    32'd7,        32'd6,        32'h0000002A, 34, 0, 1'b0);
    run_op(MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 34, 0, 1'b0);
    run_op(MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, 0, 1'b0);
    run_op(MULH,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 34, 0, 1'b0);
    run_op(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0, 1'b0);
    run_op(MULHU,  32'h00000000, 32'h12345678, 32'h00000000, 34, 0, 1'b0);
    run_op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0, 1'b0);

    // Kill a running MUL at step 10; the instruction is flushed from decode.
    @(posedge clk); #1;
    d_valid  = 1'b1;
    d_is_mul = 1'b1;
    fun      = MUL;
    rs1      = 32'h10;
    rs2      = 32'h10;
    repeat (10) @(posedge clk);
    #1;
    x_kill   = 1'b1;
    d_valid  = 1'b0;
    d_is_mul = 1'b0;
    @(posedge clk); #1;
    x_kill = 1'b0;
    @(negedge clk);
    check("kill_rd_hold", rd, 32'hFFFFFFFE);
    repeat (40) @(negedge clk);
    check("kill_rd_hold_late", rd, 32'hFFFFFFFE);
    run_op(MUL,    32'd3,        32'd4,        32'h0000000C, 34, 0, 1'b0);

    // Kill in the request cycle blocks the start, adding one stalled cycle.
    run_op(MUL,    32'd9,        32'd9,        32'h00000051, 35, 0, 1'b1);

    // Result held through five stalled DONE cycles.
    run_op(MULHU,  32'h80000000, 32'd4,        32'h00000002, 34, 5, 1'b0);

    // Asynchronous reset at step 20; the pending request restarts after release.
    issue(MULHU, 32'd2, 32'd3, 32'h00000000, -1, 0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midop_reset_rd", rd, 32'd0);
    check("midop_reset_req", {31'd0, x_stall_req}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    finish_op(0, 32'h00000000);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
